ooo_completion_buffer: RTL and testbench

OOO_COMPLETION_BUFFER -- requirements
Module: ooo_completion_buffer

---
 rtl/ooo_completion_buffer.sv | 174 +++++++++++++++++
 tb/tb_ooo_completion_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ooo_completion_buffer.sv
// Out-of-order completion buffer: in-order allocate and retire, out-of-order writeback
// from four execution ports, with a one-cycle flush on a mispredict or exception retire.
module ooo_completion_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_vd,
    input  logic             alloc_wen,
    output logic             alloc_ack,
    output logic [IDX_W-1:0] alloc_index,
    output logic             full,
    output logic             empty,
    input  logic             ready_a,
    input  logic [IDX_W-1:0] index_a,
    input  logic [31:0]      wdata_a,
    input  logic             exception_a,
    input  logic             wen_a,
    input  logic             branch_mispredict,
    input  logic             ready_mu,
    input  logic [IDX_W-1:0] index_mu,
    input  logic [31:0]      wdata_mu,
    input  logic             exception_mu,
    input  logic             ready_du,
    input  logic [IDX_W-1:0] index_du,
    input  logic [31:0]      wdata_du,
    input  logic             exception_du,
    input  logic             ready_ls,
    input  logic [IDX_W-1:0] index_ls,
    input  logic [31:0]      wdata_ls,
    input  logic             exception_ls,
    input  logic             retire_stall,
    output logic             rf_wen,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_wdata,
    output logic             retire_valid,
    output logic             flush,
    output logic             exception,
    output logic [31:0]      redirect_pc
);

    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t           state_r;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] ready_r;
    logic [DEPTH-1:0] exc_r;
    logic [DEPTH-1:0] mispred_r;
    logic [DEPTH-1:0] wen_r;
    logic [4:0]       vd_r   [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [IDX_W-1:0] head_r;
    logic [IDX_W-1:0] tail_r;
    logic [IDX_W:0]   count_r;

    logic retire_s;
    logic flush_retire_s;
    logic normal_retire_s;

    assign retire_s        = (state_r == RUN) && valid_r[head_r] && ready_r[head_r] && !retire_stall;
    assign flush_retire_s  = retire_s && (exc_r[head_r] || mispred_r[head_r]);
    assign normal_retire_s = retire_s && !flush_retire_s;

    assign full        = (count_r == (IDX_W+1)'(DEPTH));
    assign empty       = (count_r == (IDX_W+1)'(0));
    assign alloc_index = tail_r;
    assign alloc_ack   = alloc_req && !full && (state_r == RUN) && !flush_retire_s;

    // Entry storage, pointers, run/flush state and registered retire outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= RUN;
            valid_r      <= {DEPTH{1'b0}};
            ready_r      <= {DEPTH{1'b0}};
            exc_r        <= {DEPTH{1'b0}};
            mispred_r    <= {DEPTH{1'b0}};
            wen_r        <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                vd_r[i]   <= 5'd0;
                data_r[i] <= 32'd0;
            end
            head_r       <= {IDX_W{1'b0}};
            tail_r       <= {IDX_W{1'b0}};
            count_r      <= {(IDX_W+1){1'b0}};
            rf_wen       <= 1'b0;
            rf_rd        <= 5'd0;
            rf_wdata     <= 32'd0;
            retire_valid <= 1'b0;
            flush        <= 1'b0;
            exception    <= 1'b0;
            redirect_pc  <= 32'd0;
        end else begin
            retire_valid <= retire_s;
            flush        <= flush_retire_s;
            exception    <= retire_s && exc_r[head_r];
            rf_wen       <= normal_retire_s && wen_r[head_r] && (vd_r[head_r] != 5'd0);
            if (normal_retire_s) begin
                rf_rd    <= vd_r[head_r];
                rf_wdata <= data_r[head_r];
            end
            if (flush_retire_s) begin
                redirect_pc <= data_r[head_r];
            end

            case (state_r)
                RUN: begin
                    if (flush_retire_s) begin
                        valid_r <= {DEPTH{1'b0}};
                        head_r  <= {IDX_W{1'b0}};
                        tail_r  <= {IDX_W{1'b0}};
                        count_r <= {(IDX_W+1){1'b0}};
                        state_r <= FLUSH;
                    end else begin
                        // Later assignments win, giving ls > du > mu > a on a shared index.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (ready_a && valid_r[i] && (index_a == IDX_W'(i))) begin
                                ready_r[i]   <= 1'b1;
                                data_r[i]    <= wdata_a;
                                exc_r[i]     <= exception_a;
                                mispred_r[i] <= branch_mispredict;
                                wen_r[i]     <= wen_r[i] & wen_a;
                            end
                            if (ready_mu && valid_r[i] && (index_mu == IDX_W'(i))) begin
                                ready_r[i] <= 1'b1;
                                data_r[i]  <= wdata_mu;
                                exc_r[i]   <= exception_mu;
                            end
                            if (ready_du && valid_r[i] && (index_du == IDX_W'(i))) begin
                                ready_r[i] <= 1'b1;
                                data_r[i]  <= wdata_du;
                                exc_r[i]   <= exception_du;
                            end
                            if (ready_ls && valid_r[i] && (index_ls == IDX_W'(i))) begin
                                ready_r[i] <= 1'b1;
                                data_r[i]  <= wdata_ls;
                                exc_r[i]   <= exception_ls;
                            end
                        end
                        if (normal_retire_s) begin
                            valid_r[head_r] <= 1'b0;
                            ready_r[head_r] <= 1'b0;
                            head_r          <= head_r + IDX_W'(1);
                        end
                        if (alloc_ack) begin
                            valid_r[tail_r]   <= 1'b1;
                            ready_r[tail_r]   <= 1'b0;
                            exc_r[tail_r]     <= 1'b0;
                            mispred_r[tail_r] <= 1'b0;
                            wen_r[tail_r]     <= alloc_wen;
                            vd_r[tail_r]      <= alloc_vd;
                            tail_r            <= tail_r + IDX_W'(1);
                        end
                        if (alloc_ack && !normal_retire_s) begin
                            count_r <= count_r + (IDX_W+1)'(1);
                        end else if (normal_retire_s && !alloc_ack) begin
                            count_r <= count_r - (IDX_W+1)'(1);
                        end else begin
                            count_r <= count_r;
                        end
                    end
                end
                FLUSH: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ooo_completion_buffer.sv
// Directed bench for ooo_completion_buffer: ordering, full/wrap, flush, stall, priority, reset.
module tb_ooo_completion_buffer;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             CLK;
    logic             RST;
    logic             alloc_req;
    logic [4:0]       alloc_vd;
    logic             alloc_wen;
    logic             alloc_ack;
    logic [IDX_W-1:0] alloc_index;
    logic             full;
    logic             empty;
    logic             ready_a, ready_mu, ready_du, ready_ls;
    logic [IDX_W-1:0] index_a, index_mu, index_du, index_ls;
    logic [31:0]      wdata_a, wdata_mu, wdata_du, wdata_ls;
    logic             exception_a, exception_mu, exception_du, exception_ls;
    logic             wen_a;
    logic             branch_mispredict;
    logic             retire_stall;
    logic             rf_wen;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_wdata;
    logic             retire_valid;
    logic             flush;
    logic             exception;
    logic [31:0]      redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    ooo_completion_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST),
        .alloc_req(alloc_req), .alloc_vd(alloc_vd), .alloc_wen(alloc_wen),
        .alloc_ack(alloc_ack), .alloc_index(alloc_index), .full(full), .empty(empty),
        .ready_a(ready_a), .index_a(index_a), .wdata_a(wdata_a), .exception_a(exception_a),
        .wen_a(wen_a), .branch_mispredict(branch_mispredict),
        .ready_mu(ready_mu), .index_mu(index_mu), .wdata_mu(wdata_mu), .exception_mu(exception_mu),
        .ready_du(ready_du), .index_du(index_du), .wdata_du(wdata_du), .exception_du(exception_du),
        .ready_ls(ready_ls), .index_ls(index_ls), .wdata_ls(wdata_ls), .exception_ls(exception_ls),
        .retire_stall(retire_stall),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .retire_valid(retire_valid),
        .flush(flush), .exception(exception), .redirect_pc(redirect_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        alloc_req = 1'b0; alloc_vd = 5'd0; alloc_wen = 1'b0;
        ready_a = 1'b0; ready_mu = 1'b0; ready_du = 1'b0; ready_ls = 1'b0;
        index_a = 3'd0; index_mu = 3'd0; index_du = 3'd0; index_ls = 3'd0;
        wdata_a = 32'd0; wdata_mu = 32'd0; wdata_du = 32'd0; wdata_ls = 32'd0;
        exception_a = 1'b0; exception_mu = 1'b0; exception_du = 1'b0; exception_ls = 1'b0;
        wen_a = 1'b0; branch_mispredict = 1'b0; retire_stall = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic alloc_one(input logic [4:0] vd);
        alloc_req = 1'b1; alloc_vd = vd; alloc_wen = 1'b1;
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        RST = 1'b1;
        #3;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%0h exp=1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%0h exp=0", full); end
        n_checks++; if (alloc_index !== 3'd0) begin n_fail++; $display("FAIL rst_alloc_index got=%0h exp=0", alloc_index); end
        n_checks++; if ({retire_valid, rf_wen, flush, exception} !== 4'b0000) begin n_fail++; $display("FAIL rst_pulses got=%b exp=0000", {retire_valid, rf_wen, flush, exception}); end
        n_checks++; if ({rf_rd, rf_wdata, redirect_pc} !== 69'd0) begin n_fail++; $display("FAIL rst_data got=%0h/%0h/%0h exp=0", rf_rd, rf_wdata, redirect_pc); end
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_ooo_order();
        do_reset();
        alloc_req = 1'b1; alloc_vd = 5'd1; alloc_wen = 1'b1;
        #1;
        n_checks++; if (alloc_ack !== 1'b1) begin n_fail++; $display("FAIL ooo_ack got=%0h exp=1", alloc_ack); end
        n_checks++; if (alloc_index !== 3'd0) begin n_fail++; $display("FAIL ooo_idx0 got=%0h exp=0", alloc_index); end
        tick();
        alloc_vd = 5'd2; tick();
        alloc_vd = 5'd3; tick();
        alloc_req = 1'b0;
        ready_a = 1'b1; index_a = 3'd2; wdata_a = 32'hA; wen_a = 1'b1;
        tick();
        ready_a = 1'b0;
        ready_mu = 1'b1; index_mu = 3'd0; wdata_mu = 32'hB;
        tick();
        ready_mu = 1'b0;
        n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early_retire got=%0h exp=0", retire_valid); end
        ready_du = 1'b1; index_du = 3'd1; wdata_du = 32'hC;
        tick();
        ready_du = 1'b0;
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd1, 32'hB}) begin n_fail++; $display("FAIL ooo_r1 got=%0h/%0h/%0h/%0h exp=1/1/1/b", retire_valid, rf_wen, rf_rd, rf_wdata); end
        tick();
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd2, 32'hC}) begin n_fail++; $display("FAIL ooo_r2 got=%0h/%0h/%0h/%0h exp=1/1/2/c", retire_valid, rf_wen, rf_rd, rf_wdata); end
        tick();
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd3, 32'hA}) begin n_fail++; $display("FAIL ooo_r3 got=%0h/%0h/%0h/%0h exp=1/1/3/a", retire_valid, rf_wen, rf_rd, rf_wdata); end
        tick();
        n_checks++; if ({retire_valid, rf_wen, empty, rf_rd} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin n_fail++; $display("FAIL ooo_idle got=%0h/%0h/%0h/%0h exp=0/0/1/3", retire_valid, rf_wen, empty, rf_rd); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_req = 1'b1; alloc_vd = 5'(i + 1); alloc_wen = 1'b1;
            #1;
            n_checks++; if (alloc_index !== 3'(i)) begin n_fail++; $display("FAIL full_idx%0d got=%0h exp=%0h", i, alloc_index, i); end
            tick();
        end
        n_checks++; if ({full, alloc_ack, alloc_index} !== {1'b1, 1'b0, 3'd0}) begin n_fail++; $display("FAIL full_ninth got=%0h/%0h/%0h exp=1/0/0", full, alloc_ack, alloc_index); end
        ready_mu = 1'b1; index_mu = 3'd0; wdata_mu = 32'h10;
        ready_du = 1'b1; index_du = 3'd1; wdata_du = 32'h11;
        tick();
        clr_inputs();
        alloc_req = 1'b1; alloc_vd = 5'd20; alloc_wen = 1'b1;
        #1;
        n_checks++; if (alloc_ack !== 1'b0) begin n_fail++; $display("FAIL full_block got=%0h exp=0", alloc_ack); end
        tick();
        n_checks++; if ({retire_valid, rf_wdata, full, alloc_ack} !== {1'b1, 32'h10, 1'b0, 1'b1}) begin n_fail++; $display("FAIL full_retire0 got=%0h/%0h/%0h/%0h exp=1/10/0/1", retire_valid, rf_wdata, full, alloc_ack); end
        tick();
        n_checks++; if ({retire_valid, rf_wdata, full, alloc_index} !== {1'b1, 32'h11, 1'b0, 3'd1}) begin n_fail++; $display("FAIL full_both got=%0h/%0h/%0h/%0h exp=1/11/0/1", retire_valid, rf_wdata, full, alloc_index); end
        tick();
        n_checks++; if ({full, alloc_ack, alloc_index} !== {1'b1, 1'b0, 3'd2}) begin n_fail++; $display("FAIL full_refill got=%0h/%0h/%0h exp=1/0/2", full, alloc_ack, alloc_index); end
        clr_inputs();
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_one(5'd1); alloc_one(5'd2); alloc_one(5'd3);
        ready_a = 1'b1; index_a = 3'd0; wdata_a = 32'h5; wen_a = 1'b1;
        tick();
        index_a = 3'd1; wdata_a = 32'h400; branch_mispredict = 1'b1;
        ready_mu = 1'b1; index_mu = 3'd2; wdata_mu = 32'h7;
        tick();
        clr_inputs();
        n_checks++; if ({retire_valid, flush, rf_rd, rf_wdata} !== {1'b1, 1'b0, 5'd1, 32'h5}) begin n_fail++; $display("FAIL mp_pre got=%0h/%0h/%0h/%0h exp=1/0/1/5", retire_valid, flush, rf_rd, rf_wdata); end
        alloc_req = 1'b1; alloc_vd = 5'd9; alloc_wen = 1'b1;
        #1;
        n_checks++; if (alloc_ack !== 1'b0) begin n_fail++; $display("FAIL mp_ack_same got=%0h exp=0", alloc_ack); end
        tick();
        n_checks++; if ({retire_valid, flush, exception, rf_wen, redirect_pc} !== {4'b1100, 32'h400}) begin n_fail++; $display("FAIL mp_flush got=%0h/%0h/%0h/%0h/%0h exp=1/1/0/0/400", retire_valid, flush, exception, rf_wen, redirect_pc); end
        n_checks++; if ({alloc_ack, empty} !== 2'b01) begin n_fail++; $display("FAIL mp_ack_next got=%0h/%0h exp=0/1", alloc_ack, empty); end
        tick();
        n_checks++; if ({retire_valid, flush, alloc_index, alloc_ack} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL mp_after got=%0h/%0h/%0h/%0h exp=0/0/0/1", retire_valid, flush, alloc_index, alloc_ack); end
        clr_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        alloc_one(5'd4); alloc_one(5'd5);
        ready_ls = 1'b1; index_ls = 3'd0; wdata_ls = 32'h1000; exception_ls = 1'b1;
        tick();
        clr_inputs();
        alloc_req = 1'b1; alloc_vd = 5'd6; alloc_wen = 1'b1;
        #1;
        n_checks++; if (alloc_ack !== 1'b0) begin n_fail++; $display("FAIL exc_ack got=%0h exp=0", alloc_ack); end
        tick();
        alloc_req = 1'b0;
        n_checks++; if ({retire_valid, flush, exception, rf_wen, redirect_pc} !== {4'b1110, 32'h1000}) begin n_fail++; $display("FAIL exc_out got=%0h/%0h/%0h/%0h/%0h exp=1/1/1/0/1000", retire_valid, flush, exception, rf_wen, redirect_pc); end
        n_checks++; if ({empty, alloc_index} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL exc_empty got=%0h/%0h exp=1/0", empty, alloc_index); end
        tick();
        n_checks++; if ({retire_valid, flush, exception, empty} !== 4'b0001) begin n_fail++; $display("FAIL exc_after got=%b exp=0001", {retire_valid, flush, exception, empty}); end
        // exc wins over mispredict when both arrive on port a
        alloc_one(5'd8);
        ready_a = 1'b1; index_a = 3'd0; wdata_a = 32'h2000; exception_a = 1'b1; branch_mispredict = 1'b1; wen_a = 1'b1;
        tick();
        clr_inputs();
        tick();
        n_checks++; if ({flush, exception, redirect_pc} !== {2'b11, 32'h2000}) begin n_fail++; $display("FAIL exc_prio got=%0h/%0h/%0h exp=1/1/2000", flush, exception, redirect_pc); end
        tick();
    endtask

    task automatic test_stall_vd0_priority();
        do_reset();
        alloc_req = 1'b1; alloc_vd = 5'd0; alloc_wen = 1'b1; tick();
        alloc_vd = 5'd7; tick();
        alloc_req = 1'b0;
        ready_a = 1'b1; index_a = 3'd0; wdata_a = 32'h33; wen_a = 1'b1;
        retire_stall = 1'b1;
        tick();
        ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL stall_cyc%0d got=%0h exp=0", i, retire_valid); end
        end
        retire_stall = 1'b0;
        tick();
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== {1'b1, 1'b0, 5'd0, 32'h33}) begin n_fail++; $display("FAIL vd0_retire got=%0h/%0h/%0h/%0h exp=1/0/0/33", retire_valid, rf_wen, rf_rd, rf_wdata); end
        ready_a = 1'b1; index_a = 3'd1; wdata_a = 32'hAA; wen_a = 1'b1;
        ready_ls = 1'b1; index_ls = 3'd1; wdata_ls = 32'hBB;
        tick();
        clr_inputs();
        n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL prio_wb_cycle got=%0h exp=0", retire_valid); end
        tick();
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'hBB}) begin n_fail++; $display("FAIL prio_ls got=%0h/%0h/%0h/%0h exp=1/1/7/bb", retire_valid, rf_wen, rf_rd, rf_wdata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) alloc_one(5'(i + 10));
        ready_mu = 1'b1; index_mu = 3'd0; wdata_mu = 32'h55;
        ready_du = 1'b1; index_du = 3'd1; wdata_du = 32'h66;
        tick();
        clr_inputs();
        tick();
        n_checks++; if ({retire_valid, rf_wdata} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL rm_pre got=%0h/%0h exp=1/55", retire_valid, rf_wdata); end
        #2;
        RST = 1'b1;
        #1;
        n_checks++; if ({retire_valid, rf_wen, rf_rd, rf_wdata} !== 39'd0) begin n_fail++; $display("FAIL rm_async got=%0h/%0h/%0h/%0h exp=0", retire_valid, rf_wen, rf_rd, rf_wdata); end
        n_checks++; if ({empty, full, alloc_index} !== {1'b1, 1'b0, 3'd0}) begin n_fail++; $display("FAIL rm_state got=%0h/%0h/%0h exp=1/0/0", empty, full, alloc_index); end
        tick();
        RST = 1'b0;
        tick();
        tick();
        n_checks++; if ({retire_valid, flush, empty} !== 3'b001) begin n_fail++; $display("FAIL rm_after got=%b exp=001", {retire_valid, flush, empty}); end
    endtask

    initial begin
        test_reset();
        test_ooo_order();
        test_full_wrap();
        test_mispredict();
        test_exception();
        test_stall_vd0_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
